// File: rtl/ud_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ud_ctrl_if : button / auto-mode / counter bundle between ud_ctrl and its user
// Revision   : 1.0
// ----------------------------------------------------------------------------
interface ud_ctrl_if #(
  parameter int CNT_W = 4
);
  logic             btn_up;
  logic             btn_down;
  logic             auto_mode;
  logic [CNT_W-1:0] cnt;
  logic             ud;
  logic             dir_changed;

  modport master (
    output btn_up, btn_down, auto_mode, cnt,
    input  ud, dir_changed
  );

  modport slave (
    input  btn_up, btn_down, auto_mode, cnt,
    output ud, dir_changed
  );
endinterface
`default_nettype wire

// File: rtl/ud_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ud_ctrl  : debounced up/down buttons plus optional ping-pong auto-reverse
// Revision : 1.0
// ----------------------------------------------------------------------------
module ud_ctrl #(
  parameter int DB_CYCLES = 16,
  parameter int CNT_W     = 4
) (
  input  wire logic  clk,
  input  wire logic  reset_n,
  ud_ctrl_if.slave   bus
);

  localparam int               DBW         = $clog2(DB_CYCLES);
  localparam logic [DBW-1:0]   DB_LAST     = DBW'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_TOP_M1  = {{(CNT_W-1){1'b1}}, 1'b0};
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  localparam logic [0:0] ST_UP   = 1'b0;
  localparam logic [0:0] ST_DOWN = 1'b1;

  logic [1:0] w_raw;
  logic [1:0] w_press;

  assign w_raw = {bus.btn_down, bus.btn_up};

  // Index 0 = up button, index 1 = down button.
  generate
    for (genvar b = 0; b < 2; b++) begin : g_btn
      logic           s1_q;
      logic           s2_q;
      logic           db_q;
      logic           db_dly_q;
      logic [DBW-1:0] stab_q;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          s1_q     <= 1'b0;
          s2_q     <= 1'b0;
          db_q     <= 1'b0;
          db_dly_q <= 1'b0;
          stab_q   <= '0;
        end else begin
          s1_q     <= w_raw[b];
          s2_q     <= s1_q;
          db_dly_q <= db_q;
          if (s2_q == db_q) begin
            stab_q <= '0;
          end else if (stab_q == DB_LAST) begin
            db_q   <= s2_q;
            stab_q <= '0;
          end else begin
            stab_q <= stab_q + DBW'(1);
          end
        end
      end

      assign w_press[b] = db_q & ~db_dly_q;
    end
  endgenerate

  logic [0:0] state_q;
  logic [0:0] state_d;
  logic       dir_changed_q;

  // Reversal is requested one count early since the counter consumes ud on
  // the same edge, giving peaks at all-ones and troughs at zero.
  always_comb begin
    state_d = state_q;
    if (w_press[0] && w_press[1]) begin
      state_d = state_q;
    end else if (w_press[0]) begin
      state_d = ST_UP;
    end else if (w_press[1]) begin
      state_d = ST_DOWN;
    end else if (bus.auto_mode && (state_q == ST_UP) && (bus.cnt == CNT_TOP_M1)) begin
      state_d = ST_DOWN;
    end else if (bus.auto_mode && (state_q == ST_DOWN) && (bus.cnt == CNT_ONE)) begin
      state_d = ST_UP;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_UP;
      dir_changed_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      dir_changed_q <= (state_d != state_q);
    end
  end

  assign bus.ud          = state_q[0];
  assign bus.dir_changed = dir_changed_q;

endmodule
`default_nettype wire
